// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the CPU memory port
// (master) and the memory-side responder (slave).
//   req_valid/req_write/req_addr/req_wdata : request from the controller
//   req_ready                             : responder idle, can accept
//   rsp_valid/rsp_rdata/rsp_err           : single-cycle response
interface mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multi-cycle CPU.
// Accepts one word access per request, waits WAIT_CYCLES wait states and
// returns a one-cycle response. Addresses decode to a word RAM and, when
// MEM_RSP_MMIO_EN is defined, an MMIO page with an LED register
// (0x4000_000C) and a read-only free-running cycle counter (0x4000_0014).
// Without MEM_RSP_MMIO_EN every address >= 0x4000_0000 is an error and
// led is tied to 0.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mem_responder_if.slave (request + response handshake)
//   led   : LED register output
// Parameters: WAIT_CYCLES (0..15), DEPTH_WORDS (power of two, >= 2).
module mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_responder_if.slave        bus,
    output logic [7:0]            led
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        wr_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        ready_r;
    logic        valid_r;
    logic [31:0] rdata_r;
    logic        err_r;
    logic [31:0] ram_r [DEPTH_WORDS];

    logic             commit_s;
    logic             acc_wr_s;
    logic [31:0]      acc_addr_s;
    logic [31:0]      acc_wdata_s;
    logic             aligned_s;
    logic             ram_hit_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      rd_s;
    logic             err_s;

`ifdef MEM_RSP_MMIO_EN
    logic [7:0]  led_r;
    logic [31:0] cyc_r;
    logic        led_hit_s;
    logic        cyc_hit_s;
`endif

    // With zero wait states the commit edge is the acceptance edge, so the
    // access is taken straight from the bus instead of the latched copy.
    assign acc_wr_s    = (state_r == ST_IDLE) ? bus.req_write : wr_r;
    assign acc_addr_s  = (state_r == ST_IDLE) ? bus.req_addr  : addr_r;
    assign acc_wdata_s = (state_r == ST_IDLE) ? bus.req_wdata : wdata_r;

    // Commit on the edge that enters RESP; never while reset is held.
    assign commit_s = !reset &&
        (((state_r == ST_IDLE) && bus.req_valid && ready_r && (WAIT_CYCLES == 0)) ||
         ((state_r == ST_WAIT) && (cnt_r == 4'd0)));

    assign aligned_s = (acc_addr_s[1:0] == 2'b00);
    assign ram_hit_s = aligned_s && (acc_addr_s < 32'h4000_0000) &&
                       (acc_addr_s[31:2] < 30'(DEPTH_WORDS));
    assign idx_s     = acc_addr_s[IDX_W+1:2];

`ifdef MEM_RSP_MMIO_EN
    assign led_hit_s = (acc_addr_s == 32'h4000_000C);
    assign cyc_hit_s = (acc_addr_s == 32'h4000_0014);
`endif

    // Address decode: read data and error flag for the access being committed.
    always_comb begin
        rd_s  = 32'd0;
        err_s = 1'b1;
        if (ram_hit_s) begin
            err_s = 1'b0;
            if (acc_wr_s) begin
                rd_s = 32'd0;
            end else begin
                rd_s = ram_r[idx_s];
            end
        end
`ifdef MEM_RSP_MMIO_EN
        else if (led_hit_s) begin
            err_s = 1'b0;
            if (acc_wr_s) begin
                rd_s = 32'd0;
            end else begin
                rd_s = {24'd0, led_r};
            end
        end else if (cyc_hit_s) begin
            // Counter is read-only: a write reports an error.
            if (acc_wr_s) begin
                rd_s  = 32'd0;
                err_s = 1'b1;
            end else begin
                rd_s  = cyc_r;
                err_s = 1'b0;
            end
        end
`endif
        else begin
            rd_s  = 32'd0;
            err_s = 1'b1;
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            wr_r    <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_r <= 1'b0;
                    if (bus.req_valid && ready_r) begin
                        wr_r    <= bus.req_write;
                        addr_r  <= bus.req_addr;
                        wdata_r <= bus.req_wdata;
                        ready_r <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_r <= ST_RESP;
                            valid_r <= 1'b1;
                            rdata_r <= rd_s;
                            err_r   <= err_s;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= 4'(WAIT_CYCLES - 1);
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_RESP;
                        valid_r <= 1'b1;
                        rdata_r <= rd_s;
                        err_r   <= err_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Word RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (commit_s && acc_wr_s && ram_hit_s) begin
            ram_r[idx_s] <= acc_wdata_s;
        end
    end

`ifdef MEM_RSP_MMIO_EN
    // MMIO page: free-running cycle counter and LED register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_r <= 32'd0;
            led_r <= 8'd0;
        end else begin
            cyc_r <= cyc_r + 32'd1;
            if (commit_s && acc_wr_s && led_hit_s) begin
                led_r <= acc_wdata_s[7:0];
            end
        end
    end

    assign led = led_r;
`else
    assign led = 8'd0;
`endif

    assign bus.req_ready = ready_r;
    assign bus.rsp_valid = valid_r;
    assign bus.rsp_rdata = rdata_r;
    assign bus.rsp_err   = err_r;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: one instance with WAIT_CYCLES=2
// (main tests, random traffic against a reference model) and one with
// WAIT_CYCLES=0 (back-to-back throughput). Define MEM_RSP_MMIO_EN for both
// RTL and bench to exercise the MMIO page.
module tb_mem_responder;
    localparam int W     = 2;
    localparam int DEPTH = 256;
    localparam int LAT   = W + 1;

    logic       clk;
    logic       reset;
    logic [7:0] led;
    logic [7:0] led0;

    mem_responder_if m ();
    mem_responder_if m0 ();

    mem_responder #(.WAIT_CYCLES(W), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(m), .led(led)
    );

    mem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(DEPTH)) dut0 (
        .clk(clk), .reset(reset), .bus(m0), .led(led0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] mem_m [bit [29:0]];
    logic [7:0]  led_m  = 8'd0;
    logic [31:0] last_rd;
    logic        last_err;

    // Reference: outcome of one access by the address map rules.
    function automatic void ref_access(input bit wr, input logic [31:0] a,
                                       input logic [31:0] wd,
                                       output logic [31:0] rd, output bit er,
                                       output bit known);
        bit [29:0] wi;
        wi    = a[31:2];
        rd    = 32'd0;
        er    = 1'b1;
        known = 1'b1;
        if (a[1:0] != 2'b00) begin
            er = 1'b1;
        end else if (a < 32'h4000_0000) begin
            if (int'(wi) < DEPTH && wi < 30'd1024) begin
                er = 1'b0;
                if (wr) mem_m[wi] = wd;
                else if (mem_m.exists(wi)) rd = mem_m[wi];
                else known = 1'b0;
            end
        end
`ifdef MEM_RSP_MMIO_EN
        else if (a == 32'h4000_000C) begin
            er = 1'b0;
            if (wr) led_m = wd[7:0];
            else rd = {24'd0, led_m};
        end else if (a == 32'h4000_0014) begin
            if (wr) er = 1'b1;
            else begin
                er = 1'b0;
                known = 1'b0;
            end
        end
`endif
    endfunction

    // One access on the WAIT_CYCLES=2 instance, starting at a negedge with the
    // responder idle; ends at the negedge where req_ready is back.
    task automatic xact(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input string nm);
        logic [31:0] erd;
        bit          eerr;
        bit          known;
        ref_access(wr, a, wd, erd, eerr, known);
        m.req_valid = 1'b1;
        m.req_write = wr;
        m.req_addr  = a;
        m.req_wdata = wd;
        @(posedge clk);
        #1;
        // Garbage while busy must be ignored.
        m.req_valid = 1'($urandom_range(0, 1));
        m.req_write = 1'($urandom_range(0, 1));
        m.req_addr  = $urandom;
        m.req_wdata = $urandom;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            n_cmp++;
            if (m.rsp_valid !== 1'(k == LAT)) begin
                n_fail++;
                $display("FAIL %s rsp_valid cycle %0d: got %b want %b", nm, k, m.rsp_valid, k == LAT);
            end
            n_cmp++;
            if (m.req_ready !== 1'(k == LAT + 1)) begin
                n_fail++;
                $display("FAIL %s req_ready cycle %0d: got %b want %b", nm, k, m.req_ready, k == LAT + 1);
            end
            if (k == LAT) begin
                m.req_valid = 1'b0;
                last_rd  = m.rsp_rdata;
                last_err = m.rsp_err;
                n_cmp++;
                if (m.rsp_err !== eerr) begin
                    n_fail++;
                    $display("FAIL %s rsp_err: got %b want %b (addr %h)", nm, m.rsp_err, eerr, a);
                end
                if (known) begin
                    n_cmp++;
                    if (m.rsp_rdata !== erd) begin
                        n_fail++;
                        $display("FAIL %s rsp_rdata: got %h want %h (addr %h)", nm, m.rsp_rdata, erd, a);
                    end
                end
                n_cmp++;
                if (led !== led_m) begin
                    n_fail++;
                    $display("FAIL %s led: got %h want %h", nm, led, led_m);
                end
            end
            if (k == LAT + 1) begin
                n_cmp++;
                if (m.rsp_rdata !== last_rd || m.rsp_err !== last_err) begin
                    n_fail++;
                    $display("FAIL %s hold: got %h/%b want %h/%b", nm, m.rsp_rdata, m.rsp_err, last_rd, last_err);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m.req_valid = 1'b0; m.req_write = 1'b0; m.req_addr = 32'd0; m.req_wdata = 32'd0;
        m0.req_valid = 1'b0; m0.req_write = 1'b0; m0.req_addr = 32'd0; m0.req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        led_m = 8'd0;
        n_cmp++;
        if ({m.req_ready, m.rsp_valid, m.rsp_rdata, m.rsp_err, led} !== {1'b1, 1'b0, 32'd0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b rd=%h err=%b led=%h want 1 0 0 0 0",
                     m.req_ready, m.rsp_valid, m.rsp_rdata, m.rsp_err, led);
        end
        n_cmp++;
        if ({m0.req_ready, m0.rsp_valid, m0.rsp_rdata, m0.rsp_err} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state0: got rdy=%b vld=%b rd=%h err=%b want 1 0 0 0",
                     m0.req_ready, m0.rsp_valid, m0.rsp_rdata, m0.rsp_err);
        end
    endtask

    task automatic test_write_read();
        xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "wr10");
        xact(1'b0, 32'h0000_0010, 32'd0, "rd10");
        n_cmp++;
        if (last_rd !== 32'hDEAD_BEEF || last_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rd10_direct: got %h/%b want deadbeef/0", last_rd, last_err);
        end
    endtask

    task automatic test_errors();
        xact(1'b1, 32'h0000_0000, 32'h5A5A_0001, "wr0");
        xact(1'b0, 32'h0000_0402, 32'd0, "rd_misaligned");
        xact(1'b1, 32'h0000_0400, 32'hFFFF_FFFF, "wr_oob");
        n_cmp++;
        if (last_rd !== 32'd0 || last_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_direct: got %h/%b want 0/1", last_rd, last_err);
        end
        xact(1'b1, 32'h0000_0003, 32'hFFFF_FFFF, "wr_misaligned");
        xact(1'b0, 32'h0000_0000, 32'd0, "rd0_after");
    endtask

    task automatic test_mmio();
        logic [31:0] c1;
        xact(1'b1, 32'h4000_000C, 32'h0000_01A5, "wr_led");
        xact(1'b0, 32'h4000_000C, 32'd0, "rd_led");
        xact(1'b1, 32'h4000_0014, 32'h1111_1111, "wr_cyc");
        xact(1'b1, 32'h4000_0100, 32'h2222_2222, "wr_mmio_other");
`ifdef MEM_RSP_MMIO_EN
        n_cmp++;
        if (led !== 8'hA5) begin
            n_fail++;
            $display("FAIL led_direct: got %h want a5", led);
        end
        xact(1'b0, 32'h4000_0014, 32'd0, "rd_cyc1");
        c1 = last_rd;
        repeat (6) @(negedge clk);
        xact(1'b0, 32'h4000_0014, 32'd0, "rd_cyc2");
        n_cmp++;
        if (last_rd - c1 !== 32'd10) begin
            n_fail++;
            $display("FAIL cyc_delta: got %0d want 10", last_rd - c1);
        end
`else
        c1 = 32'd0;
        xact(1'b0, 32'h4000_0014, 32'd0, "rd_cyc_dis");
        n_cmp++;
        if (led !== c1[7:0] || last_err !== 1'b1) begin
            n_fail++;
            $display("FAIL mmio_disabled: got led=%h err=%b want 00/1", led, last_err);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            bit          wr;
            int          cat;
            cat = int'($urandom_range(0, 6));
            wr  = 1'($urandom_range(0, 1));
            case (cat)
                0, 1, 2: a = 32'($urandom_range(0, 31)) << 2;
                3:       a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
                4:       a = 32'($urandom_range(256, 32'h0FFF_FFFF)) << 2;
                5:       a = ($urandom_range(0, 1) != 0) ? 32'h4000_000C : 32'h4000_0014;
                default: a = ($urandom | 32'h4000_0000) & 32'hFFFF_FFFC;
            endcase
            xact(wr, a, $urandom, "random");
        end
    endtask

    task automatic test_reset_abort();
        xact(1'b1, 32'h0000_0020, 32'hCAFE_0000, "pre20");
        m.req_valid = 1'b1;
        m.req_write = 1'b1;
        m.req_addr  = 32'h0000_0020;
        m.req_wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        m.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (m.req_ready !== 1'b1 || m.rsp_valid !== 1'b0 || led !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_immediate: got rdy=%b vld=%b led=%h want 1 0 00", m.req_ready, m.rsp_valid, led);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (m.rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_rsp cycle %0d: got %b want 0", k, m.rsp_valid);
            end
        end
        reset = 1'b0;
        led_m = 8'd0;
        xact(1'b0, 32'h0000_0020, 32'd0, "post20");
    endtask

    // WAIT_CYCLES=0 instance with req_valid held high: accept every 2 cycles.
    task automatic test_back_to_back();
        logic [31:0] dat [6];
        for (int i = 0; i < 6; i++) dat[i] = $urandom;
        m0.req_valid = 1'b1;
        for (int t = 0; t < 13; t++) begin
            bit          w;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] erd;
            bit          ee;
            if (t < 6) begin
                w = 1'b1; a = 32'(t * 4); d = dat[t]; erd = 32'd0; ee = 1'b0;
            end else if (t == 6) begin
                w = 1'b0; a = 32'h0000_0001; d = 32'd0; erd = 32'd0; ee = 1'b1;
            end else begin
                w = 1'b0; a = 32'((t - 7) * 4); d = $urandom; erd = dat[t - 7]; ee = 1'b0;
            end
            m0.req_write = w;
            m0.req_addr  = a;
            m0.req_wdata = d;
            @(negedge clk);
            n_cmp++;
            if (m0.rsp_valid !== 1'b1 || m0.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_resp t=%0d: got vld=%b rdy=%b want 1 0", t, m0.rsp_valid, m0.req_ready);
            end
            n_cmp++;
            if (m0.rsp_rdata !== erd || m0.rsp_err !== ee) begin
                n_fail++;
                $display("FAIL b2b_data t=%0d: got %h/%b want %h/%b", t, m0.rsp_rdata, m0.rsp_err, erd, ee);
            end
            @(negedge clk);
            n_cmp++;
            if (m0.rsp_valid !== 1'b0 || m0.req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_idle t=%0d: got vld=%b rdy=%b want 0 1", t, m0.rsp_valid, m0.req_ready);
            end
        end
        m0.req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_errors();
        test_mmio();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multi-cycle CPU. It accepts one word read or write per request from the controller's memory port, models a fixed wait-state latency, and returns a single-cycle response. Addresses are decoded into a word RAM and, optionally, an MMIO page holding an LED register and a free-running cycle counter. It sits between the datapath's memory address/data registers and the storage.

## Interface
- `WAIT_CYCLES`, default 2: wait states between request acceptance and response (0..15).
- `DEPTH_WORDS`, default 256: RAM depth in 32-bit words (power of two).
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: write data.
- `req_ready` out 1: responder can accept; high exactly in IDLE.
- `rsp_valid` out 1: response strobe, exactly one cycle per accepted request.
- `rsp_rdata` out 32: read data; 0 for writes and errors.
- `rsp_err` out 1: access error, qualified by `rsp_valid`.
- `led` out 8: LED register.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: on `req_valid & req_ready`, latch write, address and wdata.
  - If `WAIT_CYCLES == 0`, go to RESP.
  - Otherwise go to WAIT with `cnt = WAIT_CYCLES-1`.
- WAIT: if `cnt == 0`, go to RESP and commit; else decrement `cnt`.
- Commit happens on the edge entering RESP:
  - Write: RAM or register is updated.
  - Read: `rsp_rdata` is registered.
  - `rsp_err` is registered for both.
- RESP: `rsp_valid = 1`; go unconditionally to IDLE. There is no back-pressure, so the CPU must sample in this cycle.
- Decode, applied to the latched address:
  - `addr[1:0] != 0`: error; no write; rdata 0.
  - `addr < 0x4000_0000` and word index `addr[31:2] < DEPTH_WORDS`: RAM access.
  - `addr < 0x4000_0000` and index `>= DEPTH_WORDS`: error.
  - `addr >= 0x4000_0000`: MMIO (see Configuration).
- MMIO map:
  - `0x4000_000C`: LED. Read/write; `led <= wdata[7:0]`; read returns `{24'b0, led}`.
  - `0x4000_0014`: cycle counter. Read-only; a write is an error and is not applied.
  - Any other MMIO address: error.
- Cycle counter: 32 bits, increments every cycle after reset, wraps `0xFFFF_FFFF -> 0`. A read returns the value held just before the commit edge.

## Timing
- Request accepted at edge N.
- `rsp_valid` is high in the cycle after edge `N+WAIT_CYCLES`, for exactly one cycle.
- `req_ready` is high again after edge `N+WAIT_CYCLES+1`. Next acceptance is at edge `N+WAIT_CYCLES+2` at the earliest, so throughput is 1 request per `WAIT_CYCLES+2` cycles.
- `req_*` inputs are ignored outside IDLE; changes during WAIT do not affect the pending access.
- Reset values:
  - state IDLE, so `req_ready = 1`.
  - `rsp_valid = 0`, `rsp_rdata = 0`, `rsp_err = 0`.
  - `led = 0`, counter = 0, `cnt = 0`.
  - RAM contents are not reset (undefined).
- Reset asserted in WAIT or RESP aborts the access: a pending write is not committed if reset precedes the commit edge, and no `rsp_valid` is produced.
- `rsp_rdata` and `rsp_err` hold their last value outside RESP; only `rsp_valid` qualifies them.

## Configuration
- `MEM_RSP_MMIO_EN` defined: MMIO page decoded as above; `led` is driven by the register.
- `MEM_RSP_MMIO_EN` undefined:
  - Every `addr >= 0x4000_0000` is an error with no side effect.
  - The LED register and counter are not instantiated.
  - `led` is tied to 0.

## Test plan
- Write `0xDEADBEEF` to `0x0000_0010`, then read `0x0000_0010` (`WAIT_CYCLES=2`) -> each `rsp_valid` is exactly 1 cycle, 2 cycles after acceptance; read returns `0xDEADBEEF`, `rsp_err=0`; `req_ready` is low for 3 cycles per access.
- Read `0x0000_0402` (misaligned), then write to `0x0000_0400` (index 256, `DEPTH_WORDS=256`) -> `rsp_err=1` and `rsp_rdata=0` for both; a read of word 0 is unchanged afterwards.
- MMIO enabled: write `0x1A5` to `0x4000_000C` -> `led=0xA5` from the commit edge; read returns `0x0000_00A5`. Write `0x4000_0014` -> `rsp_err=1`. Read `0x4000_0014` at two points 10 cycles apart -> values differ by 10.
- MMIO disabled: write `0x4000_000C` -> `rsp_err=1`, `led` stays 0.
- `WAIT_CYCLES=0`: back-to-back requests with `req_valid` held high -> acceptances every 2 cycles; `rsp_valid` in the cycle right after each acceptance.
- Assert `reset` during WAIT of a write of `0x1234` to `0x0000_0020` -> no `rsp_valid`; `req_ready=1` immediately; `led=0`; a later read of `0x20` does not return `0x1234` unless that word was previously written with it.
